// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// The state encodings are kept here so the planned serial adder uses the same ones.
package serial_sub_pkg;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } serial_state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_sub_1_bit.sv
// One-bit full subtractor cell: D = A - B - Bin, with the borrow out.
module sub_1_bit (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    // Difference bit and borrow: a borrow is needed when b exceeds a, or when they are equal and a borrow arrives.
    always_comb begin
        D    = A ^ B ^ Bin;
        Bout = (~A & B) | (~(A ^ B) & Bin);
    end

endmodule : sub_1_bit

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  S_IDLE | waiting for start; last result held on D/Bout/V
//  S_RUN  | one bit per edge through the cell; busy=1 for WIDTH cycles
//  S_DONE | one cycle with done=1; result valid
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    serial_state_t    r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] r_res;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_v;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    sub_1_bit u_cell (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Bin  (r_brw),
        .D    (w_d),
        .Bout (w_bout)
    );

    // The new bit enters at the MSB; after WIDTH shifts the first bit has reached bit 0.
    always_comb begin
        w_res_next = {w_d, r_res};
    end

    // Sequencer, operand shifters, borrow flop and registered result outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_brw   <= Bin;
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= B[WIDTH-1];
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_brw <= w_bout;
                    r_res <= w_res_next[WIDTH-1:1];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        // Sign overflow uses the saved MSBs; the shifted operand registers no longer hold them.
                        r_d     <= w_res_next;
                        r_bout  <= w_bout;
                        r_v     <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign D    = r_d;
    assign Bout = r_bout;
    assign V    = r_v;

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: directed cases, start/reset disturbances and a random sweep,
// all checked against plain arithmetic on the operands.
`timescale 100ns/10ns
module tb_serial_sub;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Bin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;

    logic c_a = 1'b0, c_b = 1'b0, c_bin = 1'b0;
    logic c_d, c_bout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .V     (V)
    );

    sub_1_bit u_cell (
        .A    (c_a),
        .B    (c_b),
        .Bin  (c_bin),
        .D    (c_d),
        .Bout (c_bout)
    );

    always #0.5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation from start to idle. glitch_cyc>0 re-asserts start with A=FF in that busy cycle;
    // rst_cyc>0 pulls rstn low for one cycle in that busy cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input int glitch_cyc, input int rst_cyc, input string name);
        logic [8:0] full;
        logic [7:0] ed;
        logic       eb, ev;
        int         lat, nbusy, ndone;
        lat = -1; nbusy = 0; ndone = 0;
        full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        ed = full[7:0];
        eb = full[8];
        ev = (a[7] ^ b[7]) & (a[7] ^ ed[7]);

        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= WIDTH + 4; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = i;
                chk({name, " D"}, 32'(D), 32'(ed));
                chk({name, " Bout"}, 32'(Bout), 32'(eb));
                chk({name, " V"}, 32'(V), 32'(ev));
            end
            start = 1'b0;
            A = 8'($urandom);
            B = 8'($urandom);
            Bin = 1'($urandom);
            if (i == glitch_cyc) begin
                start = 1'b1;
                A = 8'hFF;
            end
            if (rst_cyc > 0 && i == rst_cyc + 1) rstn = 1'b1;
            if (i == rst_cyc) begin
                rstn = 1'b0;
                #0.1;
                chk({name, " async busy"}, 32'(busy), 32'd0);
                chk({name, " async done"}, 32'(done), 32'd0);
                chk({name, " async D"}, 32'(D), 32'd0);
                chk({name, " async Bout"}, 32'(Bout), 32'd0);
                chk({name, " async V"}, 32'(V), 32'd0);
            end
        end
        if (rst_cyc > 0) begin
            chk({name, " done pulses"}, 32'(ndone), 32'd0);
        end else begin
            chk({name, " latency"}, 32'(lat), 32'(WIDTH + 1));
            chk({name, " busy cycles"}, 32'(nbusy), 32'(WIDTH));
            chk({name, " done pulses"}, 32'(ndone), 32'd1);
            chk({name, " D held"}, 32'(D), 32'(ed));
        end
    endtask

    initial begin
        // Cell truth table against signed arithmetic on the three bits.
        for (int k = 0; k < 8; k++) begin
            int diff;
            c_a = k[2]; c_b = k[1]; c_bin = k[0];
            #0.1;
            diff = int'(c_a) - int'(c_b) - int'(c_bin);
            chk($sformatf("cell D %0d", k), 32'(c_d), 32'(diff[0]));
            chk($sformatf("cell Bout %0d", k), 32'(c_bout), 32'(diff < 0));
        end

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset D", 32'(D), 32'd0);
        chk("reset Bout", 32'(Bout), 32'd0);
        chk("reset V", 32'(V), 32'd0);
        rstn = 1'b1;

        run_op(8'h05, 8'h03, 1'b0, 0, 0, "5-3");
        run_op(8'h03, 8'h05, 1'b0, 0, 0, "3-5");
        run_op(8'h80, 8'h01, 1'b0, 0, 0, "80-1");
        run_op(8'h00, 8'h00, 1'b1, 0, 0, "0-0-1");
        run_op(8'h05, 8'h03, 1'b0, 3, 0, "restart ignored");
        run_op(8'h05, 8'h03, 1'b0, 0, 4, "mid-run reset");
        run_op(8'h10, 8'h01, 1'b0, 0, 0, "10-1 after reset");

        for (int n = 0; n < 500; n++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 0, 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_sub
